// File: rtl/mult_booth_ctrl.sv
// mult_booth_ctrl: radix-2 Booth multiplier sequencer (IDLE/EVAL/SHIFT/DONE); ports clk, rst, start_valid/start_ready, q_lsb={LQ[0],Q_1}, mult_control={load_A,load_B,load_add,shift_HQ_LQ_Q_1,add_sub}, res_valid/res_ready, busy; `BOOTH_SKIP_EN shifts straight from EVAL on q_lsb 00/11
module mult_booth_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [1:0] q_lsb,
  output logic [4:0] mult_control,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic load_ab, load_add, shift, add_sub, last, skip;
  assign last = bit_cnt == CW'(N - 1);
`ifdef BOOTH_SKIP_EN
  assign skip = q_lsb[1] == q_lsb[0];
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (rst) bit_cnt <= '0;
    else if (shift) bit_cnt <= bit_cnt + 1'b1;
    else if (state == DONE && res_ready) bit_cnt <= '0;
  always_comb
    case (state)
      IDLE:    state_nx = start_valid ? EVAL : IDLE;
      EVAL:    state_nx = skip ? (last ? DONE : EVAL) : SHIFT;
      SHIFT:   state_nx = last ? DONE : EVAL;
      default: state_nx = res_ready ? IDLE : DONE;
    endcase
  always_comb begin
    start_ready  = !rst && state == IDLE;
    load_ab      = start_ready && start_valid;
    load_add     = !rst && state == EVAL && (q_lsb[1] ^ q_lsb[0]);
    add_sub      = load_add && q_lsb[0];
    shift        = !rst && (state == SHIFT || (state == EVAL && skip));
    res_valid    = !rst && state == DONE;
    busy         = !rst && state != IDLE;
    mult_control = {load_ab, load_ab, load_add, shift, add_sub};
  end
endmodule

// File: tb/tb_mult_booth_ctrl.sv
// tb_mult_booth_ctrl: directed cycle-by-cycle bench for mult_booth_ctrl
module tb_mult_booth_ctrl;
  logic clk = 0, rst = 1, start_valid = 0, res_ready = 0;
  logic [1:0] q_lsb = 0;
  logic start_ready, res_valid, busy;
  logic [4:0] mult_control;
  int checks = 0, errors = 0;
  mult_booth_ctrl #(.N(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .q_lsb(q_lsb), .mult_control(mult_control), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] qfor(input int mode, input int c);
    return mode == 0 ? 2'b01 : mode == 1 ? 2'b10 : mode == 2 ? 2'b00 :
           ((c - 1) % 3 == 0 ? 2'b01 : 2'b00);
  endfunction
  function automatic logic [4:0] exp_ctl(input int mode, input int c);
    logic [1:0] q;
    q = qfor(mode, c);
`ifdef BOOTH_SKIP_EN
    if (mode == 2) return 5'b00010;
    if (mode == 3) return (c - 1) % 3 == 0 ? 5'b00101 : 5'b00010;
`endif
    if (c % 2 == 0) return 5'b00010;
    return q == 2'b01 ? 5'b00101 : q == 2'b10 ? 5'b00100 : 5'b00000;
  endfunction
  function automatic int exp_lat(input int mode);
`ifdef BOOTH_SKIP_EN
    if (mode == 2) return 9;
    if (mode == 3) return 13;
`endif
    return 17;
  endfunction
  task automatic run_op(input int mode, input int bp, input logic hold);
    int lat;
    lat = exp_lat(mode);
    start_valid = 1;
    res_ready = 0;
    q_lsb = 2'b11;
    @(negedge clk);
    check("accept_ready", start_ready, 1);
    check("accept_ctl", mult_control, 5'b11000);
    check("accept_busy", busy, 0);
    tick;
    start_valid = hold;
    for (int c = 1; c < lat; c++) begin
      q_lsb = qfor(mode, c);
      @(negedge clk);
      check($sformatf("m%0d_c%0d_ctl", mode, c), mult_control, exp_ctl(mode, c));
      check($sformatf("m%0d_c%0d_rdy", mode, c), start_ready, 0);
      check($sformatf("m%0d_c%0d_rv", mode, c), res_valid, 0);
      check($sformatf("m%0d_c%0d_busy", mode, c), busy, 1);
      tick;
    end
    for (int b = 0; b <= bp; b++) begin
      res_ready = b == bp;
      @(negedge clk);
      check($sformatf("m%0d_done%0d_rv", mode, b), res_valid, 1);
      check($sformatf("m%0d_done%0d_ctl", mode, b), mult_control, 0);
      check($sformatf("m%0d_done%0d_rdy", mode, b), start_ready, 0);
      tick;
    end
    res_ready = 0;
    @(negedge clk);
    check("idle_ready", start_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_ctl", mult_control, hold ? 5'b11000 : 5'b00000);
    tick;
    start_valid = 0;
  endtask
  initial begin
    start_valid = 1;
    @(negedge clk);
    check("rst_ready", start_ready, 0);
    check("rst_ctl", mult_control, 0);
    check("rst_rv", res_valid, 0);
    check("rst_busy", busy, 0);
    tick;
    rst = 0;
    start_valid = 0;
    @(negedge clk);
    check("post_rst_ready", start_ready, 1);
    check("post_rst_ctl", mult_control, 0);
    tick;
    for (int m = 0; m < 4; m++) run_op(m, 0, 0);
    start_valid = 1;
    tick;
    start_valid = 0;
    q_lsb = 2'b01;
    for (int c = 1; c < 5; c++) tick;
    rst = 1;
    for (int c = 5; c < 7; c++) begin
      @(negedge clk);
      check("midrst_ctl", mult_control, 0);
      check("midrst_ready", start_ready, 0);
      check("midrst_rv", res_valid, 0);
      check("midrst_busy", busy, 0);
      tick;
    end
    rst = 0;
    @(negedge clk);
    check("after_rst_ready", start_ready, 1);
    check("after_rst_busy", busy, 0);
    tick;
    run_op(0, 0, 0);
    run_op(1, 5, 1);
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    check("final_idle", start_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
